alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 4, operand/result width in bits.
REQ-002 Parameter: OPW, 2, opcode width in bits.
REQ-003 The block SHALL have exactly one clock, clk. Reset is rst_n, synchronous and active-low.
REQ-004 Port: clk  input  1  sole clock, rising edge.
REQ-005 Port: rst_n  input  1  synchronous active-low reset.
REQ-006 Port: reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-007 Port: reqN_ready  output  1  requester N's operation is accepted this cycle.
REQ-008 Port: reqN_a, reqN_b  input  WIDTH  operands from requester N.
REQ-009 Port: reqN_op  input  OPW  opcode from requester N.
REQ-010 Port: alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-011 Port: alu_op  output  OPW  opcode driven to the shared ALU.
REQ-012 Port: alu_y  input  WIDTH  combinational ALU result.
REQ-013 Port: alu_cout  input  1  ALU carry/borrow out.
REQ-014 Port: rsp_valid  output  1  response available.
REQ-015 Port: rsp_ready  input  1  consumer accepts the response.
REQ-016 Port: rsp_id  output  1  index of the requester that owns the response.
REQ-017 Port: rsp_y  output  WIDTH  registered result.
REQ-018 Port: rsp_cout  output  1  registered carry.

Function
REQ-019 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-020 IDLE: when any reqN_valid=1, the block SHALL pulse the granted reqN_ready high for one cycle, register that requester's a/b/op into alu_a/alu_b/alu_op, record rsp_id, and go to EXEC. With no valid request it SHALL stay in IDLE.
REQ-021 reqN_ready SHALL be high only in IDLE, only for the granted requester, and only when that requester's reqN_valid=1. It SHALL never be high for both requesters in the same cycle.
REQ-022 Arbitration SHALL be round-robin. When both requesters are valid, the grant SHALL go to the requester not granted last. When only one is valid, that one SHALL be granted regardless of history.
REQ-023 EXEC: alu_* SHALL hold stable. At the end of the cycle, alu_y and alu_cout SHALL be captured into rsp_y and rsp_cout. The state SHALL then go to RESP.
REQ-024 RESP: rsp_valid=1, and rsp_id/rsp_y/rsp_cout SHALL hold stable until rsp_ready=1, then go to IDLE. With rsp_ready=1 on the first RESP cycle, RESP SHALL last exactly one cycle.
REQ-025 Latency: acceptance edge T, rsp_valid high from T+2. Minimum issue interval is 3 cycles.
REQ-026 reqN_valid changing while the block is in EXEC or RESP SHALL have no effect; requests wait unacknowledged.
REQ-027 Results SHALL be passed through unmodified: WIDTH bits, no saturation, wrap-around as produced by the ALU.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL set: state to IDLE; reqN_ready, rsp_valid, rsp_id, rsp_y, rsp_cout, alu_a, alu_b and alu_op to 0; last-grant to 1, so requester 0 wins the first tie.
REQ-029 Reset asserted in EXEC or RESP SHALL discard the transaction with no response.

Configuration
REQ-030 Macro ALU_ARB_FLAGS_EN: when defined, the block SHALL add output rsp_zero (1 bit), registered in EXEC as (alu_y==0) and obeying the same validity/hold rules as rsp_y, reset 0. When undefined, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Package alu_arb_pkg SHALL hold the FSM state typedef (IDLE/EXEC/RESP) and the opcode constants OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=3.
REQ-032 Sub-module rr_arb2 SHALL implement the two-way round-robin grant (inputs req[1:0], last; output gnt[1:0]) and be instantiated once.

Verification
REQ-033 After reset, req0: a=4'hA, b=4'h6, op=AND, valid=1. Required: req0_ready pulses at T; alu_a=A at T+1; alu_y=2 fed; rsp_valid at T+2 with rsp_id=0, rsp_y=4'h2.
REQ-034 Both requesters held valid, rsp_ready=1. Required: grant order 0,1,0,1, issues 3 cycles apart, never both ready in one cycle.
REQ-035 req1 ADD 4'hF+4'h1 with alu_y=0, alu_cout=1 fed. Required: rsp_y=0, rsp_cout=1, rsp_id=1; rsp_zero=1 with ALU_ARB_FLAGS_EN defined.
REQ-036 rsp_ready held 0 for 5 cycles in RESP. Required: rsp_* stable, no reqN_ready pulse; IDLE one cycle after rsp_ready=1.
REQ-037 rst_n=0 during EXEC. Required: next cycle rsp_valid=0, state IDLE, no response; a subsequent tie is granted to req0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_ADD = 2'd2;
    localparam logic [1:0] OP_SUB = 2'd3;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, shared-ALU and response signals of alu_arbiter.
// Optional macro ALU_ARB_FLAGS_EN adds the rsp_zero flag.
interface alu_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int OPW   = 2
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_y;
    logic             alu_cout;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_cout;
`ifdef ALU_ARB_FLAGS_EN
    logic             rsp_zero;
`endif

    // environment side: requesters, ALU and response consumer
    modport master (
`ifdef ALU_ARB_FLAGS_EN
        input  rsp_zero,
`endif
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_y, alu_cout, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_id, rsp_y, rsp_cout
    );

    // arbiter side
    modport slave (
`ifdef ALU_ARB_FLAGS_EN
        output rsp_zero,
`endif
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_y, alu_cout, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        output rsp_valid, rsp_id, rsp_y, rsp_cout
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. last=1 means requester 1 won the previous
// grant, so requester 0 wins a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // a lone request always wins; a tie goes to the one not granted last
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | last);
        gnt[1] = req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, one operation in
// flight at a time. Optional macro ALU_ARB_FLAGS_EN adds rsp_zero.
//
// state | meaning
// IDLE  | waiting for a request; grant pulses ready and latches operands
// EXEC  | operands held on alu_*; ALU result captured at end of cycle
// RESP  | rsp_valid high, response held until rsp_ready
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int OPW   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_arbiter_if.slave   bus
);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic             last_q;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic [1:0]       ready;
    logic             accept;
    logic             capture;
    logic             rsp_valid;

    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [OPW-1:0]   alu_op_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_y_q;
    logic             rsp_cout_q;
`ifdef ALU_ARB_FLAGS_EN
    logic             rsp_zero_q;
`endif

    assign req = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_rr_arb2 (
        .req  (req),
        .last (last_q),
        .gnt  (gnt)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state, handshakes and load strobes
    always_comb begin
        state_d   = state_q;
        ready     = 2'b00;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    ready   = rst_n ? gnt : 2'b00;
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // operand latch, owner id and round-robin history on acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            rsp_id_q <= 1'b0;
            last_q   <= 1'b1;
        end else if (accept) begin
            alu_a_q  <= gnt[1] ? bus.req1_a  : bus.req0_a;
            alu_b_q  <= gnt[1] ? bus.req1_b  : bus.req0_b;
            alu_op_q <= gnt[1] ? bus.req1_op : bus.req0_op;
            rsp_id_q <= gnt[1];
            last_q   <= gnt[1];
        end
    end

    // ALU result capture at the end of EXEC; held through RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_y_q    <= '0;
            rsp_cout_q <= 1'b0;
`ifdef ALU_ARB_FLAGS_EN
            rsp_zero_q <= 1'b0;
`endif
        end else if (capture) begin
            rsp_y_q    <= bus.alu_y;
            rsp_cout_q <= bus.alu_cout;
`ifdef ALU_ARB_FLAGS_EN
            rsp_zero_q <= (bus.alu_y == '0);
`endif
        end
    end

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_y      = rsp_y_q;
    assign bus.rsp_cout   = rsp_cout_q;
`ifdef ALU_ARB_FLAGS_EN
    assign bus.rsp_zero   = rsp_zero_q;
`endif

endmodule
